// File: rtl/pattern_match_module.sv
`default_nettype none
// ============================================================================
// Module   : pattern_match_module
// Purpose  : Byte-serial pattern matcher for one channel of the pattern-
//            matching peripheral. Holds a programmable 1..MAX_PAT byte
//            pattern and scans words of stream bytes one byte per clock,
//            detecting matches that span word boundaries. Raises a sticky
//            ACCEPTED_STATUS flag when the pattern occurs in the stream.
// Ports    :
//   clk             in  1       rising-edge clock
//   rst_n           in  1       asynchronous active-low reset
//   INP_DATA        in  DATA_W  pattern or stream bytes, byte 0 first
//   INP_CONTROL     in  CTRL_W  [15:14] cmd (00 NOP,01 LOAD,10 DATA,11 CLEAR)
//                               LOAD: [2:0]=len-1; DATA: [3:0]=N, [4]=LAST
//   DATA_VALID      in  1       INP_DATA/INP_CONTROL valid this cycle
//   READY_STATUS    out 1       transaction can be accepted this cycle
//   ACCEPTED_STATUS out 1       sticky: pattern seen since last CLEAR/LOAD
// Revision : 1.0 - initial release
// ============================================================================
module pattern_match_module #(
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 16,
  parameter int MAX_PAT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] INP_DATA,
  input  logic [CTRL_W-1:0] INP_CONTROL,
  input  logic              DATA_VALID,
  output logic              READY_STATUS,
  output logic              ACCEPTED_STATUS
);

  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_SCAN = 1'b1;

  localparam logic [1:0] C_CMD_NOP   = 2'b00;
  localparam logic [1:0] C_CMD_LOAD  = 2'b01;
  localparam logic [1:0] C_CMD_DATA  = 2'b10;
  localparam logic [1:0] C_CMD_CLEAR = 2'b11;

  localparam logic [3:0] C_MAX = 4'(MAX_PAT);

  logic [0:0]        state_q,   state_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;
  logic [3:0]        pat_len_q, pat_len_d;
  logic              pat_vld_q, pat_vld_d;
  logic [DATA_W-1:0] hist_q,    hist_d;     // byte 0 = most recent byte
  logic [3:0]        cnt_q,     cnt_d;      // saturating history fill level
  logic [DATA_W-1:0] word_q,    word_d;     // byte 0 = next byte to scan
  logic [3:0]        rem_q,     rem_d;      // bytes still to scan
  logic              last_q,    last_d;
  logic              acc_q,     acc_d;

  logic [1:0]         w_cmd;
  logic [3:0]         w_nbytes;
  logic [DATA_W-1:0]  w_hist_new;
  logic [3:0]         w_cnt_new;
  logic [MAX_PAT-1:0] w_cmp;
  logic               w_len_hit;
  logic               w_match;
  logic               w_unused_ctrl;

  assign w_cmd         = INP_CONTROL[15:14];
  assign w_unused_ctrl = &{1'b0, INP_CONTROL[13:5]};

  // A byte count of zero or above the word size means a full word.
  assign w_nbytes = ((INP_CONTROL[3:0] == 4'd0) || (INP_CONTROL[3:0] > C_MAX))
                    ? C_MAX : INP_CONTROL[3:0];

  // History and count as they will be once the current byte is shifted in.
  assign w_hist_new = {hist_q[DATA_W-9:0], word_q[7:0]};
  assign w_cnt_new  = (cnt_q == C_MAX) ? cnt_q : cnt_q + 4'd1;

  // For every candidate length l, pattern byte j must equal the byte seen
  // l-1-j bytes ago (oldest history byte lines up with pattern byte 0).
  always_comb begin
    w_cmp     = '0;
    w_len_hit = 1'b0;
    for (int l = 1; l <= MAX_PAT; l++) begin
      w_cmp[l-1] = 1'b1;
      for (int j = 0; j < l; j++) begin
        if (pattern_q[8*j +: 8] != w_hist_new[8*(l-1-j) +: 8]) begin
          w_cmp[l-1] = 1'b0;
        end
      end
      if (pat_len_q == 4'(l)) begin
        w_len_hit = w_cmp[l-1];
      end
    end
  end

  assign w_match = pat_vld_q && (w_cnt_new >= pat_len_q) && w_len_hit;

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    pat_len_d = pat_len_q;
    pat_vld_d = pat_vld_q;
    hist_d    = hist_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    rem_d     = rem_q;
    last_d    = last_q;
    acc_d     = acc_q;

    case (state_q)
      C_IDLE: begin
        if (DATA_VALID) begin
          case (w_cmd)
            C_CMD_LOAD: begin
              pattern_d = INP_DATA;
              pat_len_d = {1'b0, INP_CONTROL[2:0]} + 4'd1;
              pat_vld_d = 1'b1;
              acc_d     = 1'b0;
              hist_d    = '0;
              cnt_d     = '0;
            end
            C_CMD_DATA: begin
              word_d  = INP_DATA;
              rem_d   = w_nbytes;
              last_d  = INP_CONTROL[4];
              state_d = C_SCAN;
            end
            C_CMD_CLEAR: begin
              acc_d  = 1'b0;
              hist_d = '0;
              cnt_d  = '0;
            end
            C_CMD_NOP: begin
            end
            default: begin
            end
          endcase
        end
      end
      C_SCAN: begin
        hist_d = w_hist_new;
        cnt_d  = w_cnt_new;
        word_d = word_q >> 8;
        rem_d  = rem_q - 4'd1;
        if (w_match) begin
          acc_d = 1'b1;
        end
        if (rem_q == 4'd1) begin
          state_d = C_IDLE;
          // LAST: forget the stream so no match spans into the next word.
          if (last_q) begin
            hist_d = '0;
            cnt_d  = '0;
          end
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= C_IDLE;
      pattern_q <= '0;
      pat_len_q <= 4'd1;
      pat_vld_q <= 1'b0;
      hist_q    <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      rem_q     <= '0;
      last_q    <= 1'b0;
      acc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      pat_len_q <= pat_len_d;
      pat_vld_q <= pat_vld_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      rem_q     <= rem_d;
      last_q    <= last_d;
      acc_q     <= acc_d;
    end
  end

  assign READY_STATUS    = (state_q == C_IDLE);
  assign ACCEPTED_STATUS = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_pattern_match_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_match_module
// Purpose  : Self-checking bench for pattern_match_module. A byte-queue
//            reference model predicts READY/ACCEPTED after every clock of a
//            transaction; predictions are queued when stimulus is driven and
//            popped when the DUT is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_match_module;

  logic        clk;
  logic        rst_n;
  logic [63:0] INP_DATA;
  logic [15:0] INP_CONTROL;
  logic        DATA_VALID;
  logic        READY_STATUS;
  logic        ACCEPTED_STATUS;

  int n_checks;
  int n_errors;

  // Scoreboard entries: {expected READY, expected ACCEPTED}.
  logic [1:0] sb[$];

  // Reference model state.
  logic [63:0] m_pat;
  int          m_len;
  bit          m_valid;
  bit          m_acc;
  logic [7:0]  m_hist[$];

  pattern_match_module #(
    .DATA_W (64),
    .CTRL_W (16),
    .MAX_PAT(8)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .INP_DATA       (INP_DATA),
    .INP_CONTROL    (INP_CONTROL),
    .DATA_VALID     (DATA_VALID),
    .READY_STATUS   (READY_STATUS),
    .ACCEPTED_STATUS(ACCEPTED_STATUS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hit();
    if (!m_valid || m_hist.size() < m_len) return 1'b0;
    for (int j = 0; j < m_len; j++) begin
      if (m_hist[m_hist.size() - m_len + j] != m_pat[8*j +: 8]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_valid = 1'b0;
    m_acc   = 1'b0;
    m_len   = 1;
    m_pat   = '0;
    m_hist.delete();
  endtask

  // Drive one transaction. noise: raise DATA_VALID with a CLEAR while the
  // block is busy (must be ignored). abort_at: byte index after which rst_n
  // is pulsed mid-scan (-1 = never).
  task automatic send(input logic [63:0] d, input logic [15:0] c,
                      input bit noise, input int abort_at);
    int         n;
    logic [1:0] e;
    n = 0;
    @(negedge clk);
    check("ready_before_accept", READY_STATUS, 1'b1);
    INP_DATA    = d;
    INP_CONTROL = c;
    DATA_VALID  = 1'b1;

    case (c[15:14])
      2'b01: begin
        m_pat   = d;
        m_len   = int'(c[2:0]) + 1;
        m_valid = 1'b1;
        m_acc   = 1'b0;
        m_hist.delete();
        sb.push_back({1'b1, 1'b0});
      end
      2'b11: begin
        m_acc = 1'b0;
        m_hist.delete();
        sb.push_back({1'b1, 1'b0});
      end
      2'b00: sb.push_back({1'b1, m_acc});
      default: begin
        n = int'(c[3:0]);
        if (n == 0 || n > 8) n = 8;
        for (int i = 0; i < n; i++) begin
          m_hist.push_back(d[8*i +: 8]);
          if (m_hist.size() > 8) void'(m_hist.pop_front());
          if (m_hit()) m_acc = 1'b1;
          sb.push_back({(i == n - 1), m_acc});
        end
        if (c[4]) m_hist.delete();
      end
    endcase

    @(posedge clk);
    #1;
    DATA_VALID = 1'b0;

    if (c[15:14] != 2'b10) begin
      e = sb.pop_front();
      check("ctrl_ready", READY_STATUS, e[1]);
      check("ctrl_acc", ACCEPTED_STATUS, e[0]);
    end else begin
      check("scan_ready_e0", READY_STATUS, 1'b0);
      for (int i = 0; i < n; i++) begin
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("scan_ready", READY_STATUS, e[1]);
        check("scan_acc", ACCEPTED_STATUS, e[0]);
        if (noise && i == 4) begin
          DATA_VALID  = 1'b1;
          INP_CONTROL = 16'hC000;
        end
        if (noise && i == 6) DATA_VALID = 1'b0;
        if (i == abort_at) begin
          rst_n = 1'b0;
          #1;
          check("abort_ready", READY_STATUS, 1'b1);
          check("abort_acc", ACCEPTED_STATUS, 1'b0);
          m_reset();
          sb.delete();
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    INP_DATA    = '0;
    INP_CONTROL = '0;
    DATA_VALID  = 1'b0;
    m_reset();
    rst_n = 1'b0;
    #12;
    check("reset_ready", READY_STATUS, 1'b1);
    check("reset_acc", ACCEPTED_STATUS, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // T1: data before any LOAD never matches.
    send(64'h4241, 16'h8008, 1'b0, -1);
    // NOP has no effect.
    send(64'h0, 16'h0000, 1'b0, -1);

    // T2: in-word match, with a CLEAR attempt ignored while busy.
    send(64'h4241, 16'h4001, 1'b0, -1);
    send(64'h0000_0000_4241_0000, 16'h8008, 1'b1, -1);
    check("t2_sticky", ACCEPTED_STATUS, 1'b1);

    // T3: match across a word boundary.
    send(64'h0, 16'hC000, 1'b0, -1);
    send(64'h4100_0000_0000_0000, 16'h8008, 1'b0, -1);
    send(64'h42, 16'h8001, 1'b0, -1);

    // T4: LAST on the first word breaks the cross-word match.
    send(64'h0, 16'hC000, 1'b0, -1);
    send(64'h4100_0000_0000_0000, 16'h8018, 1'b0, -1);
    send(64'h42, 16'h8001, 1'b0, -1);

    // Match completing on the final byte of a LAST word still counts.
    send(64'h0, 16'hC000, 1'b0, -1);
    send(64'h4241_0000_0000_0000, 16'h8018, 1'b0, -1);

    // T5: partial word, bytes 4 and 5 not scanned.
    send(64'h0, 16'hC000, 1'b0, -1);
    send(64'h4241_0000_0000, 16'h8004, 1'b0, -1);
    // N = 0 and N > 8 both scan a full word.
    send(64'h4241_0000_0000, 16'h8000, 1'b0, -1);
    send(64'h0, 16'hC000, 1'b0, -1);
    send(64'h4241_0000_0000, 16'h800F, 1'b0, -1);

    // Longer patterns: 3 bytes across words, and a full 8-byte pattern.
    send(64'h43_4241, 16'h4002, 1'b0, -1);
    send(64'h4241_0000_0000_0000, 16'h8008, 1'b0, -1);
    send(64'h43, 16'h8003, 1'b0, -1);
    send(64'h0807_0605_0403_0201, 16'h4007, 1'b0, -1);
    send(64'h0807_0605_0403_0201, 16'h8008, 1'b0, -1);

    // T6: reset in the middle of the T2 scan, then data without a reload.
    send(64'h4241, 16'h4001, 1'b0, -1);
    send(64'h0000_0000_4241_0000, 16'h8008, 1'b0, 5);
    send(64'h0000_0000_4241_0000, 16'h8008, 1'b0, -1);
    send(64'h4241, 16'h4001, 1'b0, -1);
    send(64'h0000_0000_4241_0000, 16'h8008, 1'b0, -1);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
